// File: rtl/turn_sequencer.sv
// Game-flow controller: setup sequencing, alternating turns, shot resolution and win detection.
// Build option: define BONUS_SHOT_EN so that a non-winning hit keeps the shooter's turn.
module turn_sequencer #(
    parameter int SHIP_CELLS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        place_done,
    input  logic        fire,
    input  logic [2:0]  target_x,
    input  logic [2:0]  target_y,
    input  logic [63:0] p1_ships,
    input  logic [63:0] p2_ships,
    output logic [2:0]  state,
    output logic        hit,
    output logic        miss,
    output logic        reject,
    output logic [6:0]  p1_hits,
    output logic [6:0]  p2_hits
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_P1_SETUP = 3'd1,
        S_P2_SETUP = 3'd2,
        S_P1_TURN  = 3'd3,
        S_P2_TURN  = 3'd4,
        S_P1_WIN   = 3'd5,
        S_P2_WIN   = 3'd6,
        S_UNUSED   = 3'd7
    } state_t;

    localparam logic [7:0] WIN_COUNT = 8'(SHIP_CELLS);

    state_t      state_q, state_d;
    logic        start_q, place_q, fire_q;
    logic        hit_q, hit_d, miss_q, miss_d, reject_q, reject_d;
    logic [6:0]  p1_hits_q, p1_hits_d, p2_hits_q, p2_hits_d;
    logic [63:0] p1_shot_q, p1_shot_d, p2_shot_q, p2_shot_d;

    logic        start_ev, place_ev, fire_ev;
    logic        is_p1;
    logic [5:0]  idx;
    logic [63:0] shooter_shot, target_ships;
    logic [6:0]  shooter_hits, hits_inc;
    logic        win;
    state_t      other_turn;

    assign start_ev = start & ~start_q;
    assign place_ev = place_done & ~place_q;
    assign fire_ev  = fire & ~fire_q;

    // Both turn states share one resolver; is_p1 selects whose history and whose target fleet.
    assign is_p1        = (state_q == S_P1_TURN);
    assign idx          = {target_y, target_x};
    assign shooter_shot = is_p1 ? p1_shot_q : p2_shot_q;
    assign target_ships = is_p1 ? p2_ships : p1_ships;
    assign shooter_hits = is_p1 ? p1_hits_q : p2_hits_q;
    assign hits_inc     = (shooter_hits == 7'd127) ? 7'd127 : shooter_hits + 7'd1;
    assign win          = (({1'b0, shooter_hits} + 8'd1) == WIN_COUNT);
    assign other_turn   = is_p1 ? S_P2_TURN : S_P1_TURN;

    always_comb begin
        state_d   = state_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        reject_d  = 1'b0;
        p1_hits_d = p1_hits_q;
        p2_hits_d = p2_hits_q;
        p1_shot_d = p1_shot_q;
        p2_shot_d = p2_shot_q;
        case (state_q)
            S_IDLE, S_P1_WIN, S_P2_WIN: begin
                if (start_ev) begin
                    state_d   = S_P1_SETUP;
                    p1_hits_d = '0;
                    p2_hits_d = '0;
                    p1_shot_d = '0;
                    p2_shot_d = '0;
                end
            end
            S_P1_SETUP: if (place_ev) state_d = S_P2_SETUP;
            S_P2_SETUP: if (place_ev) state_d = S_P1_TURN;
            S_P1_TURN, S_P2_TURN: begin
                if (fire_ev) begin
                    if (shooter_shot[idx]) begin
                        reject_d = 1'b1;
                    end else begin
                        if (is_p1) p1_shot_d[idx] = 1'b1;
                        else       p2_shot_d[idx] = 1'b1;
                        if (target_ships[idx]) begin
                            hit_d = 1'b1;
                            if (is_p1) p1_hits_d = hits_inc;
                            else       p2_hits_d = hits_inc;
                            if (win) begin
                                state_d = is_p1 ? S_P1_WIN : S_P2_WIN;
                            end else begin
`ifdef BONUS_SHOT_EN
                                state_d = state_q;
`else
                                state_d = other_turn;
`endif
                            end
                        end else begin
                            miss_d  = 1'b1;
                            state_d = other_turn;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            place_q   <= 1'b0;
            fire_q    <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            reject_q  <= 1'b0;
            p1_hits_q <= '0;
            p2_hits_q <= '0;
            p1_shot_q <= '0;
            p2_shot_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            place_q   <= place_done;
            fire_q    <= fire;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            reject_q  <= reject_d;
            p1_hits_q <= p1_hits_d;
            p2_hits_q <= p2_hits_d;
            p1_shot_q <= p1_shot_d;
            p2_shot_q <= p2_shot_d;
        end
    end

    assign state   = state_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign reject  = reject_q;
    assign p1_hits = p1_hits_q;
    assign p2_hits = p2_hits_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer (SHIP_CELLS=2): stimulus queues expectations, a monitor compares.
module tb_turn_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, place_done = 1'b0, fire = 1'b0;
    logic [2:0]  target_x = '0, target_y = '0;
    logic [63:0] p1_ships, p2_ships;
    logic [2:0]  state;
    logic        hit, miss, reject;
    logic [6:0]  p1_hits, p2_hits;

    turn_sequencer #(.SHIP_CELLS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .place_done(place_done), .fire(fire),
        .target_x(target_x), .target_y(target_y), .p1_ships(p1_ships), .p2_ships(p2_ships),
        .state(state), .hit(hit), .miss(miss), .reject(reject),
        .p1_hits(p1_hits), .p2_hits(p2_hits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] hmr;
        logic [2:0] st;
        logic [6:0] h1;
        logic [6:0] h2;
        int         deadline;
    } pexp_t;

    typedef struct {
        logic [2:0] st;
        logic [6:0] h1;
        logic [6:0] h2;
    } sexp_t;

    pexp_t pq[$];
    sexp_t sq[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    localparam logic [2:0] HIT = 3'b100, MISS = 3'b010, REJ = 3'b001;
`ifdef BONUS_SHOT_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    // Monitor: every pulse must match the oldest queued expectation, one cycle after its fire edge.
    initial begin
        pexp_t pe;
        sexp_t se;
        forever begin
            @(negedge clk);
            cyc++;
            if (hit | miss | reject) begin
                vectors++;
                if (pq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d got hmr=%b state=%0d", cyc, {hit, miss, reject}, state);
                end else begin
                    pe = pq.pop_front();
                    if ({hit, miss, reject} != pe.hmr || state != pe.st || p1_hits != pe.h1 || p2_hits != pe.h2) begin
                        miscompares++;
                        $display("FAIL shot_result cyc=%0d got hmr=%b st=%0d h1=%0d h2=%0d required hmr=%b st=%0d h1=%0d h2=%0d",
                                 cyc, {hit, miss, reject}, state, p1_hits, p2_hits, pe.hmr, pe.st, pe.h1, pe.h2);
                    end else begin
                        $display("shot cyc=%0d hmr=%b st=%0d h1=%0d h2=%0d ok", cyc, {hit, miss, reject}, state, p1_hits, p2_hits);
                    end
                end
            end else if (pq.size() != 0 && cyc > pq[0].deadline) begin
                pe = pq.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_pulse cyc=%0d got none required hmr=%b st=%0d", cyc, pe.hmr, pe.st);
            end
            if (sq.size() != 0) begin
                se = sq.pop_front();
                vectors++;
                if (state != se.st || p1_hits != se.h1 || p2_hits != se.h2) begin
                    miscompares++;
                    $display("FAIL state_check cyc=%0d got st=%0d h1=%0d h2=%0d required st=%0d h1=%0d h2=%0d",
                             cyc, state, p1_hits, p2_hits, se.st, se.h1, se.h2);
                end else begin
                    $display("state cyc=%0d st=%0d h1=%0d h2=%0d ok", cyc, state, p1_hits, p2_hits);
                end
            end
        end
    end

    task automatic push_state(input logic [2:0] st, input logic [6:0] h1, input logic [6:0] h2);
        sq.push_back('{st: st, h1: h1, h2: h2});
    endtask

    // which: 0=start, 1=place_done; held for 'hold' cycles, state checked every cycle.
    task automatic level_pulse(input int which, input int hold,
                               input logic [2:0] st, input logic [6:0] h1, input logic [6:0] h2);
        @(negedge clk);
        if (which == 0) start = 1'b1; else place_done = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            push_state(st, h1, h2);
        end
        @(negedge clk);
        start = 1'b0;
        place_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_fire(input logic [2:0] x, input logic [2:0] y, input bit expect_pulse,
                           input logic [2:0] hmr, input logic [2:0] st, input logic [6:0] h1, input logic [6:0] h2);
        @(negedge clk);
        target_x = x;
        target_y = y;
        fire = 1'b1;
        @(posedge clk); #1;
        if (expect_pulse) pq.push_back('{hmr: hmr, st: st, h1: h1, h2: h2, deadline: cyc});
        else              push_state(st, h1, h2);
        @(negedge clk);
        fire = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        p2_ships = '0;
        p2_ships[9]  = 1'b1;
        p2_ships[10] = 1'b1;
        p1_ships = '0;
        p1_ships[63] = 1'b1;

        @(posedge clk); #1;
        push_state(3'd0, 7'd0, 7'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        push_state(3'd0, 7'd0, 7'd0);

        // Setup sequence; a 10-cycle place_done hold must advance once only.
        level_pulse(0, 1, 3'd1, 7'd0, 7'd0);
        level_pulse(1, 10, 3'd2, 7'd0, 7'd0);
        level_pulse(1, 1, 3'd3, 7'd0, 7'd0);

        do_fire(3'd1, 3'd1, 1'b1, HIT, BONUS ? 3'd3 : 3'd4, 7'd1, 7'd0);
        if (!BONUS) do_fire(3'd0, 3'd0, 1'b1, MISS, 3'd3, 7'd1, 7'd0);
        do_fire(3'd0, 3'd0, 1'b1, MISS, 3'd4, 7'd1, 7'd0);
        do_fire(3'd7, 3'd7, 1'b1, HIT, BONUS ? 3'd4 : 3'd3, 7'd1, 7'd1);
        if (BONUS) do_fire(3'd1, 3'd0, 1'b1, MISS, 3'd3, 7'd1, 7'd1);
        do_fire(3'd0, 3'd0, 1'b1, REJ, 3'd3, 7'd1, 7'd1);
        do_fire(3'd2, 3'd1, 1'b1, HIT, 3'd5, 7'd2, 7'd1);
        do_fire(3'd3, 3'd3, 1'b0, 3'b000, 3'd5, 7'd2, 7'd1);

        // New game clears counters and history; fire during setup is ignored.
        level_pulse(0, 1, 3'd1, 7'd0, 7'd0);
        do_fire(3'd1, 3'd1, 1'b0, 3'b000, 3'd1, 7'd0, 7'd0);
        level_pulse(1, 1, 3'd2, 7'd0, 7'd0);
        level_pulse(1, 1, 3'd3, 7'd0, 7'd0);
        do_fire(3'd0, 3'd0, 1'b1, MISS, 3'd4, 7'd0, 7'd0);

        level_pulse(0, 1, 3'd4, 7'd0, 7'd0);
        level_pulse(1, 1, 3'd4, 7'd0, 7'd0);

        // Reset coinciding with a fire edge in P2_TURN: no pulse, everything cleared.
        @(negedge clk);
        target_x = 3'd5;
        target_y = 3'd5;
        fire = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_state(3'd0, 7'd0, 7'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        push_state(3'd0, 7'd0, 7'd0);
        @(negedge clk);
        fire = 1'b0;
        level_pulse(0, 1, 3'd1, 7'd0, 7'd0);

        repeat (4) @(negedge clk);
        if (pq.size() != 0 || sq.size() != 0) begin
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
